// File: rtl/uart_tx_engine_if.sv
// Host-side word handshake for the UART transmit engine.
// The host drives tx_data/tx_valid; the engine returns tx_ready.
interface uart_tx_engine_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: baud counter, shift register and frame FSM.
// Frame = start, DATA_BITS data LSB-first, optional parity, STOP_BITS stop bits.
module uart_tx_engine #(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    uart_tx_engine_if.slave     s_if,
    output logic                o_tx,
    output logic                o_busy,
    output logic                o_done
);
    localparam int BDW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int BCW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               r_state, w_state_nxt;
    logic [BDW-1:0]       r_baud, w_baud_nxt;
    logic [BCW-1:0]       r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_par, w_par_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_bit_end;

    assign w_bit_end     = (r_baud == BDW'(BAUD_DIV - 1));
    assign s_if.tx_ready = (r_state == IDLE);
    assign o_busy        = (r_state != IDLE);
    assign o_tx          = r_tx;
    assign o_done        = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // tx is computed one cycle ahead so the line comes straight off a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_bit_end ? '0 : r_baud + BDW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                w_tx_nxt   = 1'b1;
                if (s_if.tx_valid) begin
                    w_state_nxt = START;
                    w_shift_nxt = s_if.tx_data;
                    w_par_nxt   = (^s_if.tx_data) ^ (PARITY_ODD != 0);
                    w_tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit == BCW'(DATA_BITS - 1)) begin
                        w_bit_nxt = '0;
                        if (PARITY_EN != 0) begin
                            w_state_nxt = PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + BCW'(1);
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_bit == BCW'(STOP_BITS - 1)) begin
                        w_state_nxt = IDLE;
                        w_bit_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + BCW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: five parameter sets side by side, expected
// line levels queued per frame and compared cycle by cycle.
module tb_uart_tx_engine;
    localparam int CDB  [5] = '{8, 8, 8, 8, 5};
    localparam int CDIV [5] = '{4, 4, 4, 4, 2};
    localparam int CPEN [5] = '{0, 1, 1, 0, 0};
    localparam int CODD [5] = '{0, 0, 1, 0, 0};
    localparam int CSTP [5] = '{1, 1, 1, 2, 1};

    logic       clk;
    logic       rst_n;
    logic [8:0] tb_data [5];
    logic [4:0] tb_valid;
    wire  [4:0] w_ready, w_tx, w_busy, w_done;

    int   n_cmp;
    int   n_bad;
    logic exp_q [$];

    uart_tx_engine_if #(.DATA_BITS(8)) if0 ();
    uart_tx_engine_if #(.DATA_BITS(8)) if1 ();
    uart_tx_engine_if #(.DATA_BITS(8)) if2 ();
    uart_tx_engine_if #(.DATA_BITS(8)) if3 ();
    uart_tx_engine_if #(.DATA_BITS(5)) if4 ();

    assign if0.tx_data = tb_data[0][7:0];  assign if0.tx_valid = tb_valid[0];  assign w_ready[0] = if0.tx_ready;
    assign if1.tx_data = tb_data[1][7:0];  assign if1.tx_valid = tb_valid[1];  assign w_ready[1] = if1.tx_ready;
    assign if2.tx_data = tb_data[2][7:0];  assign if2.tx_valid = tb_valid[2];  assign w_ready[2] = if2.tx_ready;
    assign if3.tx_data = tb_data[3][7:0];  assign if3.tx_valid = tb_valid[3];  assign w_ready[3] = if3.tx_ready;
    assign if4.tx_data = tb_data[4][4:0];  assign if4.tx_valid = tb_valid[4];  assign w_ready[4] = if4.tx_ready;

    uart_tx_engine #(.DATA_BITS(8), .BAUD_DIV(4)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(if0),
        .o_tx(w_tx[0]), .o_busy(w_busy[0]), .o_done(w_done[0]));
    uart_tx_engine #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY_EN(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(if1),
        .o_tx(w_tx[1]), .o_busy(w_busy[1]), .o_done(w_done[1]));
    uart_tx_engine #(.DATA_BITS(8), .BAUD_DIV(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(if2),
        .o_tx(w_tx[2]), .o_busy(w_busy[2]), .o_done(w_done[2]));
    uart_tx_engine #(.DATA_BITS(8), .BAUD_DIV(4), .STOP_BITS(2)) u3 (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(if3),
        .o_tx(w_tx[3]), .o_busy(w_busy[3]), .o_done(w_done[3]));
    uart_tx_engine #(.DATA_BITS(5), .BAUD_DIV(2)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(if4),
        .o_tx(w_tx[4]), .o_busy(w_busy[4]), .o_done(w_done[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected line level for each bit of the frame, in transmit order.
    task automatic push_frame(input int k, input logic [8:0] d);
        logic p;
        p = 1'b0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < CDB[k]; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (CPEN[k] != 0) exp_q.push_back((CODD[k] != 0) ? ~p : p);
        for (int i = 0; i < CSTP[k]; i++) exp_q.push_back(1'b1);
    endtask

    // Returns just after the accepting edge; valid stays high when hold=1.
    task automatic start_word(input int k, input logic [8:0] d, input bit hold);
        bit seen;
        seen = 1'b0;
        tb_data[k]  = d;
        tb_valid[k] = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = w_ready[k];
        end
        if (!seen) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) tb_valid[k] = 1'b0;
        push_frame(k, d);
    endtask

    // Checks every cycle of one frame, then the first idle cycle.
    task automatic check_frame(input int k);
        int   nb;
        logic e;
        nb = 1 + CDB[k] + CPEN[k] + CSTP[k];
        for (int b = 0; b < nb; b++) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
                e = 1'b1;
            end else begin
                e = exp_q.pop_front();
            end
            for (int c = 0; c < CDIV[k]; c++) begin
                @(negedge clk);
                chk("tx_bit", w_tx[k], e);
                chk("ready_low", w_ready[k], 1'b0);
                chk("busy_high", w_busy[k], 1'b1);
                chk("done_low", w_done[k], 1'b0);
            end
        end
        @(negedge clk);
        chk("done_pulse", w_done[k], 1'b1);
        chk("end_ready", w_ready[k], 1'b1);
        chk("end_busy", w_busy[k], 1'b0);
        chk("end_tx", w_tx[k], 1'b1);
    endtask

    task automatic idle_after(input int k);
        @(negedge clk);
        chk("done_once", w_done[k], 1'b0);
        chk("idle_tx", w_tx[k], 1'b1);
        chk("idle_busy", w_busy[k], 1'b0);
    endtask

    task automatic send(input int k, input logic [8:0] d);
        start_word(k, d, 1'b0);
        check_frame(k);
        idle_after(k);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        tb_valid = '0;
        for (int k = 0; k < 5; k++) tb_data[k] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("rst_tx", w_tx[k], 1'b1);
            chk("rst_ready", w_ready[k], 1'b1);
            chk("rst_busy", w_busy[k], 1'b0);
            chk("rst_done", w_done[k], 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        send(0, 9'h0A5);
        send(1, 9'h0A5);
        send(2, 9'h0A5);
        send(1, 9'h001);
        send(3, 9'h0FF);

        // Back-to-back with valid held: second accept lands on the done cycle.
        start_word(0, 9'h011, 1'b1);
        tb_data[0] = 9'h022;
        push_frame(0, 9'h022);
        check_frame(0);
        @(posedge clk);
        #1;
        tb_valid[0] = 1'b0;
        check_frame(0);
        idle_after(0);

        // Host changes tx_data while busy: frame must carry the latched word.
        start_word(0, 9'h03C, 1'b0);
        tb_data[0] = 9'h0C3;
        check_frame(0);
        idle_after(0);

        // Reset during data bit 3 (a 0 bit), then a clean frame.
        start_word(0, 9'h052, 1'b0);
        repeat (18) @(negedge clk);
        chk("pre_rst_tx", w_tx[0], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_tx", w_tx[0], 1'b1);
        chk("abort_busy", w_busy[0], 1'b0);
        chk("abort_ready", w_ready[0], 1'b1);
        chk("abort_done", w_done[0], 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_done", w_done[0], 1'b0);
            chk("post_rst_tx", w_tx[0], 1'b1);
        end
        send(0, 9'h052);

        send(4, 9'h01F);
        send(4, 9'h00A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
